// File: rtl/spr_pkg.sv
// spr_pkg: shared definitions for the special-register bypass scoreboard.
//   - source-kind encodings driven on ex_kind
//   - minimum tracked depth and the elaboration-time depth check helper
package spr_pkg;

  localparam logic [1:0] KIND_NONE = 2'd0;
  localparam logic [1:0] KIND_CP0  = 2'd1;
  localparam logic [1:0] KIND_HL   = 2'd2;

  localparam int DEPTH_MIN = 1;

  function automatic bit depth_ok(input int depth);
    return depth >= DEPTH_MIN;
  endfunction

endpackage

// File: rtl/spr_fwd_lookup.sv
// spr_fwd_lookup: youngest-match forwarding selector for one EX operand.
// Ports:
//   use_i, addr_i   operand read enable and register address
//   v_i/rw_i/cp0_i/rdy_i/data_i  flattened scoreboard entries, stage k at slice k
//   cp0_dout_i      live CP0 read data for the stage-0 instruction
//   hit_o, data_o   forward enable and value
//   stall_o         matched producer has no value yet
module spr_fwd_lookup
  import spr_pkg::*;
#(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 2
) (
  input  logic                  use_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DEPTH-1:0]      v_i,
  input  logic [DEPTH-1:0]      cp0_i,
  input  logic [DEPTH-1:0]      rdy_i,
  input  logic [DEPTH*AW-1:0]   rw_i,
  input  logic [DEPTH*DW-1:0]   data_i,
  input  logic [DW-1:0]         cp0_dout_i,
  output logic                  hit_o,
  output logic [DW-1:0]         data_o,
  output logic                  stall_o
);

  logic          found;
  logic          m_rdy;
  logic          m_cp0;
  logic          m_s0;
  logic [DW-1:0] m_data;

  always_comb begin
    found  = 1'b0;
    m_rdy  = 1'b0;
    m_cp0  = 1'b0;
    m_s0   = 1'b0;
    m_data = '0;
    // Scan oldest to youngest so the youngest match is the one left standing.
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (v_i[k] && (rw_i[k*AW +: AW] == addr_i)) begin
        found  = 1'b1;
        m_rdy  = rdy_i[k];
        m_cp0  = cp0_i[k];
        m_s0   = (k == 0);
        m_data = data_i[k*DW +: DW];
      end
    end

    hit_o   = 1'b0;
    data_o  = '0;
    stall_o = 1'b0;
    if (use_i && (addr_i != '0) && found) begin
      if (m_rdy) begin
        hit_o  = 1'b1;
        data_o = m_data;
      end else if (m_cp0 && m_s0) begin
        // CP0 read happens in stage 0; its data is on the bus this cycle.
        hit_o  = 1'b1;
        data_o = cp0_dout_i;
      end else if (!m_cp0) begin
        stall_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spr_bypass_sb.sv
// spr_bypass_sb: scoreboard of in-flight GPR writes sourced from CP0 or HI/LO,
// tracked through DEPTH post-EX stages, with per-operand forwarding and an
// EX stall when the youngest matching producer has no value yet.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   hold, flush       pipeline freeze; kill stage 0 and this cycle's push
//   ex_wr/ex_rw/ex_kind/ex_hl  EX producer description
//   md_busy, md_done, md_result  mult/div status and late HI/LO result
//   cp0_dout          CP0 read data for the stage-0 instruction
//   src_addr, src_use consumer operands in EX
//   fwd_hit, fwd_data forwarding result per operand
//   stall, stall_cnt  EX stall and saturating stall-cycle counter
module spr_bypass_sb
  import spr_pkg::*;
#(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 2,
  parameter int NSRC  = 2,
  parameter int CW    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold,
  input  logic                 flush,
  input  logic                 ex_wr,
  input  logic [AW-1:0]        ex_rw,
  input  logic [1:0]           ex_kind,
  input  logic [DW-1:0]        ex_hl,
  input  logic                 md_busy,
  input  logic                 md_done,
  input  logic [DW-1:0]        md_result,
  input  logic [DW-1:0]        cp0_dout,
  input  logic [NSRC*AW-1:0]   src_addr,
  input  logic [NSRC-1:0]      src_use,
  output logic [NSRC-1:0]      fwd_hit,
  output logic [NSRC*DW-1:0]   fwd_data,
  output logic                 stall,
  output logic [CW-1:0]        stall_cnt
);

  if (!depth_ok(DEPTH)) begin : g_depth_chk
    $error("spr_bypass_sb: DEPTH must be at least 1");
  end

  typedef struct packed {
    logic          v;
    logic [AW-1:0] rw;
    logic          cp0;
    logic          rdy;
    logic [DW-1:0] data;
  } entry_t;

  localparam logic [CW-1:0] CNT_MAX = '1;

  entry_t ent_q [DEPTH];
  entry_t ent_d [DEPTH];
  entry_t push;
  logic   push_ok;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [DEPTH-1:0]    v_vec, cp0_vec, rdy_vec;
  logic [DEPTH*AW-1:0] rw_vec;
  logic [DEPTH*DW-1:0] data_vec;
  logic [NSRC-1:0]     stall_req;

  always_comb begin
    v_vec    = '0;
    cp0_vec  = '0;
    rdy_vec  = '0;
    rw_vec   = '0;
    data_vec = '0;
    for (int k = 0; k < DEPTH; k++) begin
      v_vec[k]              = ent_q[k].v;
      cp0_vec[k]            = ent_q[k].cp0;
      rdy_vec[k]            = ent_q[k].rdy;
      rw_vec[k*AW +: AW]    = ent_q[k].rw;
      data_vec[k*DW +: DW]  = ent_q[k].data;
    end
  end

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    spr_fwd_lookup #(
      .DW    (DW),
      .AW    (AW),
      .DEPTH (DEPTH)
    ) u_lookup (
      .use_i      (src_use[i]),
      .addr_i     (src_addr[i*AW +: AW]),
      .v_i        (v_vec),
      .cp0_i      (cp0_vec),
      .rdy_i      (rdy_vec),
      .rw_i       (rw_vec),
      .data_i     (data_vec),
      .cp0_dout_i (cp0_dout),
      .hit_o      (fwd_hit[i]),
      .data_o     (fwd_data[i*DW +: DW]),
      .stall_o    (stall_req[i])
    );
  end

  always_comb stall = |stall_req;

  // Entry entering stage 0 this edge; a stalled EX inserts a bubble.
  always_comb begin
    push    = '0;
    push_ok = ex_wr && !stall && !flush && (ex_rw != '0) &&
              ((ex_kind == KIND_CP0) || (ex_kind == KIND_HL));
    if (push_ok) begin
      push.v  = 1'b1;
      push.rw = ex_rw;
      if (ex_kind == KIND_CP0) begin
        push.cp0 = 1'b1;
      end else if (!md_busy) begin
        push.rdy  = 1'b1;
        push.data = ex_hl;
      end else if (md_done) begin
        push.rdy  = 1'b1;
        push.data = md_result;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) ent_d[k] = ent_q[k];
    if (!hold) begin
      ent_d[0] = push;
      for (int k = 1; k < DEPTH; k++) begin
        ent_d[k] = ent_q[k-1];
        if (k == 1) begin
          if (flush) begin
            ent_d[k] = '0;
          end else if (ent_q[0].cp0 && !ent_q[0].rdy) begin
            ent_d[k].data = cp0_dout;
            ent_d[k].rdy  = 1'b1;
          end
        end
      end
    end else if (flush) begin
      ent_d[0] = '0;
    end
    // Late mult/div result lands at each entry's post-shift position.
    if (md_done) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (ent_d[k].v && !ent_d[k].rdy && !ent_d[k].cp0) begin
          ent_d[k].data = md_result;
          ent_d[k].rdy  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && !hold && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) ent_q[k] <= '0;
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) ent_q[k] <= ent_d[k];
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_spr_bypass_sb.sv
module tb_spr_bypass_sb;
  import spr_pkg::*;

  localparam int DW = 32, AW = 5, DEPTH = 2, NSRC = 2, CW = 16;
  localparam int MAX_CYCLES = 2000;

  logic              clk = 1'b0;
  logic              rst, hold, flush, ex_wr, md_busy, md_done;
  logic [AW-1:0]     ex_rw;
  logic [1:0]        ex_kind;
  logic [DW-1:0]     ex_hl, md_result, cp0_dout;
  logic [NSRC*AW-1:0] src_addr;
  logic [NSRC-1:0]   src_use;
  logic [NSRC-1:0]   fwd_hit;
  logic [NSRC*DW-1:0] fwd_data;
  logic              stall;
  logic [CW-1:0]     stall_cnt;

  always #5 clk = ~clk;

  spr_bypass_sb #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .NSRC(NSRC), .CW(CW)) dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush),
    .ex_wr(ex_wr), .ex_rw(ex_rw), .ex_kind(ex_kind), .ex_hl(ex_hl),
    .md_busy(md_busy), .md_done(md_done), .md_result(md_result),
    .cp0_dout(cp0_dout), .src_addr(src_addr), .src_use(src_use),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .stall(stall), .stall_cnt(stall_cnt)
  );

  typedef struct {
    string       name;
    logic [1:0]  hit;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        st;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycles = 0;

  always @(posedge clk) begin
    cycles++;
    if (cycles > MAX_CYCLES) begin
      errors++;
      $display("FAIL timeout: simulation exceeded %0d cycles", MAX_CYCLES);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  // Monitor: outputs are presented every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (fwd_hit !== e.hit || fwd_data[31:0] !== e.d0 || fwd_data[63:32] !== e.d1 ||
          stall !== e.st || stall_cnt !== e.cnt) begin
        errors++;
        $display("FAIL %s: got hit=%b d0=%h d1=%h stall=%b cnt=%0d, want hit=%b d0=%h d1=%h stall=%b cnt=%0d",
                 e.name, fwd_hit, fwd_data[31:0], fwd_data[63:32], stall, stall_cnt,
                 e.hit, e.d0, e.d1, e.st, e.cnt);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hold = 0; flush = 0; ex_wr = 0; ex_rw = '0; ex_kind = KIND_NONE; ex_hl = '0;
    md_busy = 0; md_done = 0; md_result = '0; cp0_dout = '0;
    src_addr = '0; src_use = '0;
  endtask

  task automatic push(input logic [1:0] kind, input logic [4:0] rw,
                      input logic [31:0] hl, input logic busy);
    ex_wr = 1; ex_kind = kind; ex_rw = rw; ex_hl = hl; md_busy = busy;
  endtask

  task automatic src(input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] u);
    src_addr = {a1, a0}; src_use = u;
  endtask

  task automatic expect_out(input string name, input logic [1:0] hit, input logic [31:0] d0,
                            input logic [31:0] d1, input logic st, input logic [15:0] cnt);
    exp_t e;
    e.name = name; e.hit = hit; e.d0 = d0; e.d1 = d1; e.st = st; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  initial begin
    idle();
    rst = 1;
    step(); step();
    rst = 0;

    checks++;
    if (fwd_hit !== '0 || fwd_data !== '0 || stall !== 1'b0 || stall_cnt !== '0) begin
      errors++;
      $display("FAIL reset_direct: got hit=%b data=%h stall=%b cnt=%0d, want all zero",
               fwd_hit, fwd_data, stall, stall_cnt);
    end

    // Reset state
    idle(); expect_out("reset", 2'b00, 0, 0, 0, 0); step();

    // HL push, forward from stage 0 then stage 1, then retired
    idle(); push(KIND_HL, 8, 32'h1234, 0); expect_out("hl_push", 0, 0, 0, 0, 0); step();
    idle(); src(8, 0, 2'b01); expect_out("hl_s0", 2'b01, 32'h1234, 0, 0, 0); step();
    idle(); src(8, 0, 2'b01); expect_out("hl_s1", 2'b01, 32'h1234, 0, 0, 0); step();
    idle(); src(8, 0, 2'b01); expect_out("hl_retired", 0, 0, 0, 0, 0); step();

    // CP0 push: live cp0_dout in stage 0, captured value in stage 1
    idle(); push(KIND_CP0, 9, 32'hDEAD, 0); step();
    idle(); cp0_dout = 32'hCAFE; src(0, 9, 2'b10); expect_out("cp0_s0", 2'b10, 0, 32'hCAFE, 0, 0); step();
    idle(); src(0, 9, 2'b10); expect_out("cp0_s1", 2'b10, 0, 32'hCAFE, 0, 0); step();
    idle(); src(0, 9, 2'b10); expect_out("cp0_retired", 0, 0, 0, 0, 0); step();

    // HL while mult/div busy: stall, count, late capture under hold
    idle(); push(KIND_HL, 3, 32'h7777, 1); step();
    idle(); md_busy = 1; src(3, 0, 2'b01); expect_out("md_stall0", 0, 0, 0, 1, 0); step();
    idle(); md_busy = 1; hold = 1; md_done = 1; md_result = 32'h55; src(3, 0, 2'b01);
    expect_out("md_stall1", 0, 0, 0, 1, 1); step();
    idle(); src(3, 0, 2'b01); expect_out("md_done_fwd", 2'b01, 32'h55, 0, 0, 1); step();

    // Youngest ready match wins
    idle(); push(KIND_HL, 4, 32'h11, 0); step();
    idle(); push(KIND_HL, 4, 32'h22, 0); src(4, 0, 2'b01); expect_out("yw_old_s0", 2'b01, 32'h11, 0, 0, 1); step();
    idle(); src(4, 0, 2'b01); expect_out("yw_young", 2'b01, 32'h22, 0, 0, 1); step();
    idle(); src(4, 0, 2'b01); expect_out("yw_young_s1", 2'b01, 32'h22, 0, 0, 1); step();

    // Younger unready match stalls despite an older ready one
    idle(); push(KIND_HL, 4, 32'h11, 0); step();
    idle(); push(KIND_HL, 4, 32'h99, 1); step();
    idle(); src(4, 0, 2'b01); expect_out("yu_stall", 0, 0, 0, 1, 1); step();
    idle(); src(4, 0, 2'b01); expect_out("yu_stall_s1", 0, 0, 0, 1, 2); step();
    idle(); src(4, 0, 2'b01); expect_out("yu_retired", 0, 0, 0, 0, 3); step();

    // Flush kills stage 0 and the push; stage 1 still hits, then retires
    idle(); push(KIND_HL, 6, 32'h66, 0); step();
    idle(); push(KIND_HL, 5, 32'h77, 0); step();
    idle(); flush = 1; push(KIND_HL, 7, 32'h88, 0); src(5, 6, 2'b11);
    expect_out("flush_pre", 2'b11, 32'h77, 32'h66, 0, 3); step();
    idle(); src(5, 7, 2'b11); expect_out("flush_post", 0, 0, 0, 0, 3); step();
    idle(); src(0, 6, 2'b10); expect_out("flush_s1_ret", 0, 0, 0, 0, 3); step();

    // Address 0 push is a bubble; address 0 lookup never hits
    idle(); push(KIND_HL, 0, 32'hAA, 0); step();
    idle(); src(0, 0, 2'b11); expect_out("addr0", 0, 0, 0, 0, 3); step();

    // Unused operand gets no forward; kind NONE push is a bubble
    idle(); push(KIND_HL, 10, 32'hBB, 0); step();
    idle(); push(KIND_NONE, 11, 32'hCC, 0); src(10, 10, 2'b10);
    expect_out("unused_op", 2'b10, 0, 32'hBB, 0, 3); step();
    idle(); src(11, 0, 2'b01); expect_out("kind_none", 0, 0, 0, 0, 3); step();

    // Hold keeps entries in place
    idle(); push(KIND_HL, 12, 32'hC1, 0); step();
    idle(); hold = 1; src(12, 0, 2'b01); expect_out("hold_a", 2'b01, 32'hC1, 0, 0, 3); step();
    idle(); hold = 1; src(12, 0, 2'b01); expect_out("hold_b", 2'b01, 32'hC1, 0, 0, 3); step();
    idle(); src(12, 0, 2'b01); expect_out("hold_c", 2'b01, 32'hC1, 0, 0, 3); step();
    idle(); src(12, 0, 2'b01); expect_out("hold_s1", 2'b01, 32'hC1, 0, 0, 3); step();
    idle(); src(12, 0, 2'b01); expect_out("hold_ret", 0, 0, 0, 0, 3); step();

    // Reset during a stall discards the pending md_done
    idle(); push(KIND_HL, 3, 32'h1, 1); step();
    idle(); md_busy = 1; rst = 1; md_done = 1; md_result = 32'h99; src(3, 0, 2'b01);
    expect_out("rst_during", 0, 0, 0, 1, 3); step();
    rst = 0;
    idle(); md_busy = 1; src(3, 0, 2'b01); expect_out("rst_after", 0, 0, 0, 0, 0); step();
    idle(); md_done = 1; md_result = 32'h99; src(3, 0, 2'b01); expect_out("rst_md_late", 0, 0, 0, 0, 0); step();
    idle(); src(3, 0, 2'b01); expect_out("rst_md_late2", 0, 0, 0, 0, 0); step();

    idle(); step(); step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
